ahb_response_mux: RTL and testbench

AHB-Lite slave-to-master response multiplexer for the two-slave interconnect; the return-path counterpart of the address decoder. It registers the decoder's slave selects at the end of each address phase and routes the selected slave's HRDATA, HREADYOUT and HRESP back to the master during the data phase. When no transfer is active it supplies the default OKAY response. A wait-state watchdog terminates any data phase stalled beyond a limit with a two-cycle AHB ERROR response.

---
 rtl/ahb_response_mux.sv | 144 ++++++++++++++
 tb/tb_ahb_response_mux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_response_mux.sv
// AHB-Lite response mux for a two-slave interconnect, with a wait-state watchdog.
// Ports: HCLK/HRESET, decoder selects + HTRANS, slave responses in, muxed HRDATA/HREADY/HRESP + HTIMEOUT out.
module ahb_response_mux #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxWait   = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSELOne,
  input  logic                 HSELTwo,
  input  logic [1:0]           HTRANS,
  input  logic [DataWidth-1:0] HRDATAOne,
  input  logic [DataWidth-1:0] HRDATATwo,
  input  logic                 HREADYOUTOne,
  input  logic                 HREADYOUTTwo,
  input  logic                 HRESPOne,
  input  logic                 HRESPTwo,
  output logic [DataWidth-1:0] HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic                 HTIMEOUT
);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ONE,
    SEL_TWO
  } sel_e;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [7:0] CntLast = 8'(MaxWait - 1);

  state_e     state_q, state_d;
  sel_e       sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;

  sel_e                 addr_sel;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_ready;
  logic                 sel_resp;
  logic                 wait_cyc;

  // Slave one wins when the decoder raises both selects.
  always_comb begin
    addr_sel = SEL_NONE;
    if (HTRANS[1] && HSELOne) begin
      addr_sel = SEL_ONE;
    end else if (HTRANS[1] && HSELTwo) begin
      addr_sel = SEL_TWO;
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_ready = 1'b1;
    sel_resp  = 1'b0;
    unique case (sel_q)
      SEL_ONE: begin
        sel_data  = HRDATAOne;
        sel_ready = HREADYOUTOne;
        sel_resp  = HRESPOne;
      end
      SEL_TWO: begin
        sel_data  = HRDATATwo;
        sel_ready = HREADYOUTTwo;
        sel_resp  = HRESPTwo;
      end
      default: begin
        sel_data  = '0;
        sel_ready = 1'b1;
        sel_resp  = 1'b0;
      end
    endcase
  end

  // NONE always reports ready, so a stall implies an active slave.
  assign wait_cyc = (state_q == ST_NORMAL) && !sel_ready;

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    unique case (state_q)
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        HRDATA = sel_data;
        HREADY = sel_ready;
        HRESP  = sel_resp;
      end
    endcase
  end

  assign HTIMEOUT = (state_q == ST_ERR1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (HREADY) begin
      sel_d = addr_sel;
      cnt_d = '0;
    end
    unique case (state_q)
      ST_NORMAL: begin
        if (wait_cyc) begin
          if (cnt_q == CntLast) begin
            state_d = ST_ERR1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_NORMAL;
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_NORMAL;
      sel_q   <= SEL_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_response_mux.sv
// Directed bench for ahb_response_mux with MaxWait = 4.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_ahb_response_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELOne, HSELTwo;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATAOne, HRDATATwo;
  logic        HREADYOUTOne, HREADYOUTTwo;
  logic        HRESPOne, HRESPTwo;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP, HTIMEOUT;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_response_mux #(
    .DataWidth(32),
    .MaxWait  (4)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSELOne     (HSELOne),
    .HSELTwo     (HSELTwo),
    .HTRANS      (HTRANS),
    .HRDATAOne   (HRDATAOne),
    .HRDATATwo   (HRDATATwo),
    .HREADYOUTOne(HREADYOUTOne),
    .HREADYOUTTwo(HREADYOUTTwo),
    .HRESPOne    (HRESPOne),
    .HRESPTwo    (HRESPTwo),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HTIMEOUT    (HTIMEOUT)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [31:0] d,
                         input logic rdy, input logic rsp,
                         input logic tmo);
    chk({tag, ".hrdata"}, HRDATA, d);
    chk({tag, ".hready"}, {31'd0, HREADY}, {31'd0, rdy});
    chk({tag, ".hresp"}, {31'd0, HRESP}, {31'd0, rsp});
    chk({tag, ".htimeout"}, {31'd0, HTIMEOUT}, {31'd0, tmo});
  endtask

  task automatic idle_addr();
    HTRANS  = 2'b00;
    HSELOne = 1'b0;
    HSELTwo = 1'b0;
  endtask

  initial begin
    // Reset with random everything
    HRESET       = 1'b1;
    HSELOne      = 1'($urandom);
    HSELTwo      = 1'($urandom);
    HTRANS       = 2'($urandom);
    HRDATAOne    = $urandom;
    HRDATATwo    = $urandom;
    HREADYOUTOne = 1'($urandom);
    HREADYOUTTwo = 1'($urandom);
    HRESPOne     = 1'($urandom);
    HRESPTwo     = 1'($urandom);
    tick();
    #1 chk_bus("rst1", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    #1 chk_bus("rst2", 32'h0, 1'b1, 1'b0, 1'b0);

    // Slave one, zero wait, then idle
    HRESET       = 1'b0;
    HTRANS       = 2'b10;
    HSELOne      = 1'b1;
    HSELTwo      = 1'b0;
    HRESPOne     = 1'b0;
    HRESPTwo     = 1'b0;
    HREADYOUTOne = 1'b1;
    HREADYOUTTwo = 1'b1;
    tick();
    idle_addr();
    HRDATAOne = 32'hDEADBEEF;
    #1 chk_bus("s1_data", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    #1 chk_bus("s1_idle", 32'h0, 1'b1, 1'b0, 1'b0);

    // Slave two, three wait states
    HTRANS       = 2'b10;
    HSELTwo      = 1'b1;
    HRDATATwo    = 32'h12345678;
    HREADYOUTTwo = 1'b0;
    tick();
    idle_addr();
    for (int i = 0; i < 3; i++) begin
      #1 chk_bus("s2_wait", 32'h12345678, 1'b0, 1'b0, 1'b0);
      tick();
    end
    HREADYOUTTwo = 1'b1;
    #1 chk_bus("s2_done", 32'h12345678, 1'b1, 1'b0, 1'b0);
    tick();
    #1 chk_bus("s2_idle", 32'h0, 1'b1, 1'b0, 1'b0);

    // Timeout: slave one never ready
    HTRANS       = 2'b10;
    HSELOne      = 1'b1;
    HRDATAOne    = 32'hA5A5A5A5;
    HREADYOUTOne = 1'b0;
    tick();
    idle_addr();
    for (int i = 0; i < 4; i++) begin
      #1 chk_bus("to_wait", 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
      tick();
    end
    #1 chk_bus("to_err1", 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    #1 chk_bus("to_err2", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    #1 chk_bus("to_norm", 32'h0, 1'b1, 1'b0, 1'b0);

    // Ready rises exactly on the last tolerated wait cycle
    HTRANS  = 2'b10;
    HSELOne = 1'b1;
    tick();
    idle_addr();
    for (int i = 0; i < 3; i++) begin
      #1 chk_bus("edge_wait", 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
      tick();
    end
    HREADYOUTOne = 1'b1;
    #1 chk_bus("edge_done", 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    tick();
    #1 chk_bus("edge_after", 32'h0, 1'b1, 1'b0, 1'b0);

    // Genuine two-cycle ERROR from slave two
    HTRANS  = 2'b10;
    HSELTwo = 1'b1;
    tick();
    idle_addr();
    HRDATATwo    = 32'h0BADF00D;
    HRESPTwo     = 1'b1;
    HREADYOUTTwo = 1'b0;
    #1 chk_bus("serr1", 32'h0BADF00D, 1'b0, 1'b1, 1'b0);
    tick();
    HREADYOUTTwo = 1'b1;
    #1 chk_bus("serr2", 32'h0BADF00D, 1'b1, 1'b1, 1'b0);
    tick();
    HRESPTwo = 1'b0;
    #1 chk_bus("serr_idle", 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-to-back alternating slaves, both select lines high once
    HTRANS    = 2'b10;
    HSELOne   = 1'b1;
    HSELTwo   = 1'b1;
    HRDATAOne = 32'h11111111;
    HRDATATwo = 32'h22222222;
    tick();
    HSELOne = 1'b0;
    #1 chk_bus("b2b_1", 32'h11111111, 1'b1, 1'b0, 1'b0);
    tick();
    HSELOne = 1'b1;
    HSELTwo = 1'b0;
    #1 chk_bus("b2b_2", 32'h22222222, 1'b1, 1'b0, 1'b0);
    tick();
    idle_addr();
    #1 chk_bus("b2b_3", 32'h11111111, 1'b1, 1'b0, 1'b0);
    tick();

    // Reset during ERR1, then a fresh transfer
    HTRANS       = 2'b10;
    HSELOne      = 1'b1;
    HREADYOUTOne = 1'b0;
    tick();
    idle_addr();
    for (int i = 0; i < 4; i++) tick();
    #1 chk_bus("rerr_err1", 32'h0, 1'b0, 1'b1, 1'b1);
    HRESET = 1'b1;
    tick();
    HRESET    = 1'b0;
    HTRANS    = 2'b10;
    HSELOne   = 1'b1;
    HRDATAOne = 32'h77777777;
    #1 chk_bus("rerr_rst", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_addr();
    HREADYOUTOne = 1'b1;
    HRDATAOne    = 32'hCAFEF00D;
    #1 chk_bus("rerr_new", 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    tick();
    #1 chk_bus("rerr_idle", 32'h0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
